data_mem_access: RTL and testbench

//   Load/store unit between the CPU data path and the word-wide single-port data RAM (async read, sync write,
//   no byte enables). Converts byte/half/word requests into word accesses, doing read-modify-write for
//   sub-word stores and lane extraction plus sign/zero extension for loads. Flags misaligned accesses.

---
 rtl/data_mem_access.sv | 153 +++++++++++++++
 tb/tb_data_mem_access.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// Load/store unit between the CPU data path and a word-wide single-port RAM.
// Byte and half loads pick out the requested lane and sign- or zero-extend it.
// Byte and half stores read the whole word, merge in the new lane(s), then write it back.
// Misaligned addresses and the illegal size code complete at once with o_Error set.
//
// Handshake: i_Req is sampled only while the unit is idle (o_Busy=0).
// All request fields are latched on the edge that accepts the request.
// Exactly one o_Ack pulse follows each accepted request.
// The requester must drop i_Req in the o_Ack cycle, otherwise it is taken as a new request.
module data_mem_access #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Req,
    input  logic                      i_WrEnable,
    input  logic [1:0]                i_Size,
    input  logic                      i_Unsigned,
    input  logic [ADDR_WIDTH-1:0]     i_Addr,
    input  logic [31:0]               i_WrData,
    output logic [31:0]               o_RdData,
    output logic                      o_Ack,
    output logic                      o_Error,
    output logic                      o_Busy,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    output logic                      o_MemWrEnable,
    output logic [31:0]               o_MemWrData,
    input  logic [31:0]               i_MemRdData,
    output logic [2:0]                o_DbgState
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]                r_State;
    logic [MEM_ADDR_WIDTH+1:0] r_Addr;
    logic [1:0]                r_Size;
    logic                      r_Unsigned;
    logic                      r_WrEnable;
    logic [31:0]               r_WrWord;
    logic [31:0]               r_RdData;

    logic                      w_Misaligned;
    logic [4:0]                w_ShiftAmt;
    logic [31:0]               w_Shifted;
    logic [31:0]               w_LoadValue;
    logic [31:0]               w_LaneMask;
    logic [31:0]               w_MergedWord;
    logic                      w_unused_addr;

    // Address bits above the RAM range alias and are deliberately dropped.
    assign w_unused_addr = ^i_Addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    // Alignment and size legality of the incoming request (only used in IDLE).
    always_comb begin
        w_Misaligned = 1'b0;
        case (i_Size)
            SZ_BYTE: w_Misaligned = 1'b0;
            SZ_HALF: w_Misaligned = i_Addr[0];
            SZ_WORD: w_Misaligned = (i_Addr[1:0] != 2'b00);
            default: w_Misaligned = 1'b1;
        endcase
    end

    // Lane shift: the little-endian byte offset times eight.
    assign w_ShiftAmt = {r_Addr[1:0], 3'b000};
    assign w_Shifted  = i_MemRdData >> w_ShiftAmt;

    // Load path: bring the addressed lane to bit 0, then extend it to 32 bits.
    always_comb begin
        w_LoadValue = i_MemRdData;
        case (r_Size)
            SZ_BYTE: w_LoadValue = {{24{~r_Unsigned & w_Shifted[7]}}, w_Shifted[7:0]};
            SZ_HALF: w_LoadValue = {{16{~r_Unsigned & w_Shifted[15]}}, w_Shifted[15:0]};
            default: w_LoadValue = i_MemRdData;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the word read from RAM.
    always_comb begin
        w_LaneMask = 32'h0000_00FF;
        if (r_Size == SZ_HALF) begin
            w_LaneMask = 32'h0000_FFFF;
        end
        w_MergedWord = (i_MemRdData & ~(w_LaneMask << w_ShiftAmt)) |
                       ((r_WrWord & w_LaneMask) << w_ShiftAmt);
    end

    // Main FSM, request latches, load result and write-back word.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State    <= S_IDLE;
            r_Addr     <= '0;
            r_Size     <= SZ_BYTE;
            r_Unsigned <= 1'b0;
            r_WrEnable <= 1'b0;
            r_WrWord   <= 32'h0;
            r_RdData   <= 32'h0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (i_Req) begin
                        r_Addr     <= i_Addr[MEM_ADDR_WIDTH+1:0];
                        r_Size     <= i_Size;
                        r_Unsigned <= i_Unsigned;
                        r_WrEnable <= i_WrEnable;
                        r_WrWord   <= i_WrData;
                        if (w_Misaligned) begin
                            r_State <= S_ERR;
                        end else if (i_WrEnable && (i_Size == SZ_WORD)) begin
                            r_State <= S_WRITE;
                        end else begin
                            r_State <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_WrEnable) begin
                        r_WrWord <= w_MergedWord;
                        r_State  <= S_WRITE;
                    end else begin
                        r_RdData <= w_LoadValue;
                        r_State  <= S_DONE;
                    end
                end
                S_WRITE: r_State <= S_DONE;
                S_DONE:  r_State <= S_IDLE;
                S_ERR:   r_State <= S_IDLE;
                default: r_State <= S_IDLE;
            endcase
        end
    end

    // Outputs come only from state and latched registers.
    // A reset mid-write therefore drops the write enable at once.
    assign o_RdData      = r_RdData;
    assign o_Ack         = (r_State == S_DONE) || (r_State == S_ERR);
    assign o_Error       = (r_State == S_ERR);
    assign o_Busy        = (r_State != S_IDLE);
    assign o_MemAddr     = r_Addr[MEM_ADDR_WIDTH+1:2];
    assign o_MemWrEnable = (r_State == S_WRITE);
    assign o_MemWrData   = r_WrWord;
    assign o_DbgState    = r_State;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access.
// A behavioural RAM model serves the unit: async read, write on the clock edge.
// The bench uses a vector table plus hand-written reset and held-request sequences.
module tb_data_mem_access;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        int          ram_idx;
        logic [31:0] exp_ram;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        ack;
    logic        err;
    logic        busy;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] ram [0:1023];
    logic        ram_clear;
    int          wr_cnt  = 0;
    int          ack_cnt = 0;
    int          checks  = 0;
    int          failures = 0;
    vec_t        vecs [22];

    data_mem_access #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Req         (req),
        .i_WrEnable    (we),
        .i_Size        (size),
        .i_Unsigned    (uns),
        .i_Addr        (addr),
        .i_WrData      (wdata),
        .o_RdData      (rd_data),
        .o_Ack         (ack),
        .o_Error       (err),
        .o_Busy        (busy),
        .o_MemAddr     (mem_addr),
        .o_MemWrEnable (mem_we),
        .o_MemWrData   (mem_wdata),
        .i_MemRdData   (mem_rdata),
        .o_DbgState    (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // RAM model: async read, synchronous write.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int k = 0; k < 1024; k++) ram[k] <= 32'h0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // Event counters for writes and acks seen at clock edges.
    always @(posedge clk) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (ack)    ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v_we, input logic [1:0] v_size, input logic v_uns,
                                input logic [31:0] v_addr, input logic [31:0] v_wdata,
                                input logic [31:0] v_rd, input logic v_err, input int v_lat,
                                input int v_wr, input int v_idx, input logic [31:0] v_ram);
        vec_t v;
        v.we = v_we; v.size = v_size; v.uns = v_uns; v.addr = v_addr; v.wdata = v_wdata;
        v.exp_rd = v_rd; v.exp_err = v_err; v.exp_lat = v_lat; v.exp_wr = v_wr;
        v.ram_idx = v_idx; v.exp_ram = v_ram;
        return v;
    endfunction

    // Issue one request, drop i_Req after the accepting edge, and check the whole transaction.
    task automatic do_req(input vec_t v, input string tag);
        int lat;
        int w0;
        int a0;
        @(negedge clk);
        we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata; req = 1'b1;
        w0 = wr_cnt;
        a0 = ack_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ack && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_error"}, {31'b0, err}, {31'b0, v.exp_err});
        chk({tag, "_rddata"}, rd_data, v.exp_rd);
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'b0, busy, ack}, 32'h0);
        chk({tag, "_ram"}, ram[v.ram_idx], v.exp_ram);
        chk({tag, "_writes"}, wr_cnt - w0, v.exp_wr);
        chk({tag, "_acks"}, ack_cnt - a0, 1);
    endtask

    initial begin
        int w0;
        int a0;
        int lat;
        int stray;

        // Directed vectors; expected values worked out by hand from the lane rules.
        vecs[0]  = mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h00000000, 0, 2, 1, 4, 32'hDEADBEEF);
        vecs[1]  = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0, 4, 32'hDEADBEEF);
        vecs[2]  = mk(1, 2'b10, 0, 32'h10,   32'h11223344, 32'hDEADBEEF, 0, 2, 1, 4, 32'h11223344);
        vecs[3]  = mk(1, 2'b00, 0, 32'h13,   32'h000001AA, 32'hDEADBEEF, 0, 3, 1, 4, 32'hAA223344);
        vecs[4]  = mk(0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFFAA, 0, 2, 0, 4, 32'hAA223344);
        vecs[5]  = mk(0, 2'b00, 1, 32'h13,   32'h0,        32'h000000AA, 0, 2, 0, 4, 32'hAA223344);
        vecs[6]  = mk(1, 2'b01, 0, 32'h10,   32'h00008001, 32'h000000AA, 0, 3, 1, 4, 32'hAA228001);
        vecs[7]  = mk(0, 2'b01, 0, 32'h10,   32'h0,        32'hFFFF8001, 0, 2, 0, 4, 32'hAA228001);
        vecs[8]  = mk(0, 2'b01, 1, 32'h10,   32'h0,        32'h00008001, 0, 2, 0, 4, 32'hAA228001);
        vecs[9]  = mk(0, 2'b10, 0, 32'h11,   32'h0,        32'h00008001, 1, 1, 0, 4, 32'hAA228001);
        vecs[10] = mk(1, 2'b01, 0, 32'h13,   32'h0000FFFF, 32'h00008001, 1, 1, 0, 4, 32'hAA228001);
        vecs[11] = mk(1, 2'b11, 0, 32'h10,   32'h00000000, 32'h00008001, 1, 1, 0, 4, 32'hAA228001);
        vecs[12] = mk(1, 2'b00, 0, 32'h21,   32'h12345655, 32'h00008001, 0, 3, 1, 8, 32'h00005500);
        vecs[13] = mk(1, 2'b01, 0, 32'h22,   32'hABCDBEEF, 32'h00008001, 0, 3, 1, 8, 32'hBEEF5500);
        vecs[14] = mk(0, 2'b01, 0, 32'h22,   32'h0,        32'hFFFFBEEF, 0, 2, 0, 8, 32'hBEEF5500);
        vecs[15] = mk(0, 2'b00, 1, 32'h21,   32'h0,        32'h00000055, 0, 2, 0, 8, 32'hBEEF5500);
        vecs[16] = mk(0, 2'b00, 0, 32'h23,   32'h0,        32'hFFFFFFBE, 0, 2, 0, 8, 32'hBEEF5500);
        vecs[17] = mk(0, 2'b00, 0, 32'h20,   32'h0,        32'h00000000, 0, 2, 0, 8, 32'hBEEF5500);
        vecs[18] = mk(1, 2'b10, 0, 32'h1000, 32'h12345678, 32'h00000000, 0, 2, 1, 0, 32'h12345678);
        vecs[19] = mk(0, 2'b10, 0, 32'h0,    32'h0,        32'h12345678, 0, 2, 0, 0, 32'h12345678);
        vecs[20] = mk(0, 2'b01, 1, 32'h12,   32'h0,        32'h0000AA22, 0, 2, 0, 4, 32'hAA228001);
        vecs[21] = mk(0, 2'b01, 0, 32'h12,   32'h0,        32'hFFFFAA22, 0, 2, 0, 4, 32'hAA228001);

        // Reset block.
        rst = 1'b1; ram_clear = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; ram_clear = 1'b0;
        @(negedge clk);
        chk("reset_rddata", rd_data, 32'h0);
        chk("reset_ack_err_busy", {29'b0, ack, err, busy}, 32'h0);
        chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
        chk("reset_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);

        for (int i = 0; i < 22; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end

        // Load with i_Req held through the busy period and fields changed after acceptance.
        @(negedge clk);
        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h0; req = 1'b1;
        w0 = wr_cnt;
        a0 = ack_cnt;
        @(posedge clk);
        #1 addr = 32'h10; size = 2'b00;
        @(negedge clk);
        chk("hold_mem_addr_latched", {22'b0, mem_addr}, 32'd8);
        lat = 1;
        while (!ack && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        req = 1'b0;
        chk("hold_latency", lat, 2);
        chk("hold_rddata", rd_data, 32'hBEEF5500);
        repeat (4) @(negedge clk);
        chk("hold_single_ack", ack_cnt - a0, 1);
        chk("hold_no_write", wr_cnt - w0, 0);
        chk("hold_idle", {31'b0, busy}, 32'h0);

        // Sub-word store aborted by reset while in WRITE.
        @(negedge clk);
        we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h12; wdata = 32'h00000077; req = 1'b1;
        w0 = wr_cnt;
        a0 = ack_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_write", {31'b0, mem_we}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we_dropped", {31'b0, mem_we}, 32'h0);
        chk("abort_busy_cleared", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) stray++;
        end
        chk("abort_no_ack_pulse", stray, 0);
        chk("abort_ack_count", ack_cnt - a0, 0);
        chk("abort_write_count", wr_cnt - w0, 0);
        chk("abort_ram_unchanged", ram[4], 32'hAA228001);
        chk("abort_rddata_reset", rd_data, 32'h0);

        // The unit still works normally after the abort.
        do_req(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hAA228001, 0, 2, 0, 4, 32'hAA228001), "post_reset_lw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
